// File: rtl/sine_nco.sv
// Quadrature sine/cosine NCO: a phase accumulator drives a quarter-wave table
// through a 3-stage pipeline (address, folded table read, sign/output).
// Optional build macro: SINE_NCO_DITHER_EN adds LFSR phase dithering ahead of
// the table-address truncation. Latency is 3 cycles in both builds.
module sine_nco #(
    parameter int PHASE_WIDTH = 24,
    parameter int LUT_DEPTH   = 8,
    parameter int DATA_WIDTH  = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [PHASE_WIDTH-1:0]       phase_inc,
    input  logic [PHASE_WIDTH-1:0]       phase_offset,
    input  logic                         sync_clr,
    output logic signed [DATA_WIDTH-1:0] sin_out,
    output logic signed [DATA_WIDTH-1:0] cos_out,
    output logic                         out_valid
);

    localparam int Q  = 2 ** (LUT_DEPTH - 2);
    localparam int A  = 2 ** (DATA_WIDTH - 1) - 1;
    localparam int MW = DATA_WIDTH - 1;
    localparam logic [LUT_DEPTH-2:0] Q_IDX  = (LUT_DEPTH-1)'(Q);
    localparam logic [LUT_DEPTH-1:0] Q_ADDR = LUT_DEPTH'(Q);

    // Quarter-wave magnitude; the peak entry is pinned to A so float error
    // can never pull it down to A-1.
    function automatic logic [MW-1:0] quarter_val(input int k);
        real x;
        if (k >= Q) return MW'(A);
        x = real'(A) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(2 ** LUT_DEPTH));
        return MW'($rtoi(x));
    endfunction

    // Odd quadrants read the table mirrored (Q - l); even ones read it directly.
    function automatic logic [LUT_DEPTH-2:0] fold_idx(input logic [LUT_DEPTH-2:0] a_lo);
        logic [LUT_DEPTH-2:0] l;
        l = {1'b0, a_lo[LUT_DEPTH-3:0]};
        return a_lo[LUT_DEPTH-2] ? (Q_IDX - l) : l;
    endfunction

    logic [MW-1:0] w_lut [0:Q];
    for (genvar k = 0; k <= Q; k++) begin : g_lut
        assign w_lut[k] = quarter_val(k);
    end

    logic [PHASE_WIDTH-1:0] r_acc;
    logic [PHASE_WIDTH-1:0] w_acc_base;
    logic [PHASE_WIDTH-1:0] w_p;
    logic [LUT_DEPTH-1:0]   w_addr;
    logic [LUT_DEPTH-1:0]   w_addr_c;
    logic [LUT_DEPTH-1:0]   r_addr1;
    logic [3:1]             r_vld_pipe;
    logic [MW-1:0]          r_mag_s;
    logic [MW-1:0]          r_mag_c;
    logic                   r_neg_s;
    logic                   r_neg_c;
    logic signed [DATA_WIDTH-1:0] w_mag_s;
    logic signed [DATA_WIDTH-1:0] w_mag_c;

    // A sync_clr sample sees acc = 0 even though the register updates later.
    assign w_acc_base = sync_clr ? '0 : r_acc;

`ifdef SINE_NCO_DITHER_EN
    localparam int DITH_W = (PHASE_WIDTH - LUT_DEPTH < 16) ? (PHASE_WIDTH - LUT_DEPTH) : 16;
    logic [15:0]            r_lfsr;
    logic [PHASE_WIDTH-1:0] w_dith;

    // Fibonacci LFSR, taps 16,14,13,11; steps once per accepted sample.
    always_ff @(posedge clk) begin
        if (rst)     r_lfsr <= 16'hACE1;
        else if (en) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    // Zero-extended low LFSR bits, sized to the truncated phase fraction.
    always_comb begin
        w_dith = '0;
        for (int i = 0; i < DITH_W; i++) w_dith[i] = r_lfsr[i];
    end

    assign w_p = w_acc_base + phase_offset + w_dith;
`else
    assign w_p = w_acc_base + phase_offset;
`endif

    assign w_addr   = w_p[PHASE_WIDTH-1 -: LUT_DEPTH];
    assign w_addr_c = r_addr1 + Q_ADDR;

    // Bits below the table address only matter through the carry chain.
    if (PHASE_WIDTH > LUT_DEPTH) begin : g_frac
        logic w_unused_frac;
        assign w_unused_frac = ^w_p[PHASE_WIDTH-LUT_DEPTH-1:0];
    end

    // Phase accumulator: en adds the tuning word, sync_clr alone zeroes it.
    always_ff @(posedge clk) begin
        if (rst)           r_acc <= '0;
        else if (en)       r_acc <= w_acc_base + phase_inc;
        else if (sync_clr) r_acc <= '0;
    end

    // S1: capture table address; valid bits shift every cycle so en=0 makes bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr1    <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[2:1], en};
            if (en) r_addr1 <= w_addr;
        end
    end

    // S2: folded table reads; the upper quadrant bit marks the negative half-wave.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag_s <= '0;
            r_mag_c <= '0;
            r_neg_s <= 1'b0;
            r_neg_c <= 1'b0;
        end else if (r_vld_pipe[1]) begin
            r_mag_s <= w_lut[fold_idx(r_addr1[LUT_DEPTH-2:0])];
            r_mag_c <= w_lut[fold_idx(w_addr_c[LUT_DEPTH-2:0])];
            r_neg_s <= r_addr1[LUT_DEPTH-1];
            r_neg_c <= w_addr_c[LUT_DEPTH-1];
        end
    end

    assign w_mag_s = $signed({1'b0, r_mag_s});
    assign w_mag_c = $signed({1'b0, r_mag_c});

    // S3: apply sign; magnitudes never exceed A so -2^(DATA_WIDTH-1) is unreachable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sin_out <= '0;
            cos_out <= '0;
        end else if (r_vld_pipe[2]) begin
            sin_out <= r_neg_s ? -w_mag_s : w_mag_s;
            cos_out <= r_neg_c ? -w_mag_c : w_mag_c;
        end
    end

    assign out_valid = r_vld_pipe[3];

endmodule

// File: doc/sine_nco.md
SINE_NCO -- requirements
Module: sine_nco

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 24: phase accumulator width in bits.
REQ-002 SHALL have parameter LUT_DEPTH, default 8: full-wave address width in bits, giving 2^LUT_DEPTH points per cycle; legal range 4..PHASE_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 7: signed output width in bits.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: sample strobe; one output sample per cycle in which en=1.
REQ-007 SHALL have port phase_inc, input, PHASE_WIDTH bits: unsigned tuning word added per sample.
REQ-008 SHALL have port phase_offset, input, PHASE_WIDTH bits: phase added to the accumulator value before lookup.
REQ-009 SHALL have port sync_clr, input, 1 bit: clears the accumulator phase.
REQ-010 SHALL have port sin_out, output, DATA_WIDTH bits, signed: sine sample.
REQ-011 SHALL have port cos_out, output, DATA_WIDTH bits, signed: cosine sample.
REQ-012 SHALL have port out_valid, output, 1 bit: sin_out and cos_out carry a new sample this cycle.

Function
REQ-013 SHALL hold a quarter-wave table T[k], k = 0..Q with Q = 2^(LUT_DEPTH-2): T[k] = trunc(A*sin(2*pi*k/2^LUT_DEPTH)) where A = 2^(DATA_WIDTH-1)-1, and T[Q] = A exactly.
REQ-014 SHALL form the sample phase p = (acc + phase_offset) mod 2^PHASE_WIDTH, where acc is 0 if sync_clr=1 in that cycle.
REQ-015 SHALL take a = p[PHASE_WIDTH-1 -: LUT_DEPTH], quadrant q = a[top 2 bits], and low field l = a[LUT_DEPTH-3:0].
REQ-016 SHALL produce the sine value by quadrant: q=0 gives +T[l]; q=1 gives +T[Q-l]; q=2 gives -T[l]; q=3 gives -T[Q-l].
REQ-017 SHALL produce cos_out from the same rule applied to address (a + Q) mod 2^LUT_DEPTH.
REQ-018 SHALL update the accumulator as follows: if en=1, acc <= (sync_clr ? 0 : acc) + phase_inc, modulo 2^PHASE_WIDTH with silent wrap; else if sync_clr=1, acc <= 0; otherwise acc holds.
REQ-019 SHALL use a 3-stage pipeline: S1 registers the address and valid; S2 registers the folded table reads and quadrants; S3 applies the sign and registers the outputs.
REQ-020 SHALL assert out_valid exactly 3 cycles after a cycle with en=1, for 1 cycle per sample; consecutive en cycles give back-to-back valid cycles.
REQ-021 SHALL propagate en=0 cycles as bubbles; in a bubble, sin_out and cos_out hold their last values and out_valid=0.
REQ-022 SHALL NOT flush the pipeline on sync_clr; samples already in flight complete unchanged.
REQ-023 SHALL sample phase_inc and phase_offset only in cycles with en=1; changing them takes effect on the next such sample.
REQ-024 SHALL never output -2^(DATA_WIDTH-1); the output range is symmetric, -A..+A.

Reset
REQ-025 SHALL, while rst=1, set acc=0, all pipeline valid bits=0, sin_out=0, cos_out=0 and out_valid=0, overriding en and sync_clr.
REQ-026 SHALL discard in-flight samples on reset mid-operation; the first sample after reset uses acc=0.

Configuration
REQ-027 SHALL compile in phase dithering when macro SINE_NCO_DITHER_EN is defined.
REQ-028 With SINE_NCO_DITHER_EN defined:
- a 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances once per en=1 cycle;
- its low D bits, D = min(16, PHASE_WIDTH-LUT_DEPTH), zero-extended, are added to p before truncation.
REQ-029 Without SINE_NCO_DITHER_EN, p SHALL be truncated with no LFSR present; latency is 3 in both builds.

Verification (defaults, macro undefined)
REQ-030 Reset, then en=1 continuously, phase_inc=24'h010000, phase_offset=0 -> out_valid rises 3 cycles later; sin_out = 0,1,3,4,...; cos_out = 63,62,62,...
REQ-031 phase_offset=24'h800000, phase_inc=24'h010000 -> sin_out = 0,-1,-3,-4 (7'h00,7'h7F,7'h7D,7'h7C); cos_out = -63,-62 (7'h41,7'h42).
REQ-032 phase_inc=24'hFF0000 (one step backward) -> sin_out = 0,-1,-3 and cos_out = 63,62,62; the accumulator wraps 0 -> 24'hFF0000.
REQ-033 en pattern 1,0,1 -> out_valid pattern 1,0,1 delayed by 3 cycles; outputs held during the gap; second sample sin_out=1.
REQ-034 After 10 samples, sync_clr=1 with en=1 -> that sample gives sin_out=0 and cos_out=63 three cycles later, and the next sample gives sin_out=1.
REQ-035 rst pulsed for 1 cycle while out_valid=1 -> next cycle out_valid=0, sin_out=0, cos_out=0; the first post-reset sample matches REQ-030.
